// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered write-back stage selecting ALU result or extended load lane data
module wb_stage_pipe #(
   parameter  int XLEN       = 32,
   parameter  int REG_ADDR_W = 5,
   parameter  int OPCODE_W   = 10,
   parameter  int LOAD_BIT   = 4,
   localparam int LANE_W     = $clog2(XLEN/8)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  rd_write_en_i,
   input  logic [REG_ADDR_W-1:0] rd_id_i,
   input  logic [OPCODE_W-1:0]   opcode_info_i,
   input  logic [XLEN-1:0]       alu_result_i,
   input  logic [1:0]            ld_size_i,
   input  logic                  ld_unsigned_i,
   input  logic                  flush_i,
   input  logic                  mem_rvalid_i,
   input  logic [XLEN-1:0]       mem_read_data_i,
   output logic                  wb_rd_write_en_o,
   output logic [REG_ADDR_W-1:0] wb_rd_id_o,
   output logic [XLEN-1:0]       wb_rd_write_data_o,
   output logic                  misalign_o
);
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
   state_t state, state_n;
   logic accept, is_ld, mis_in, alu_wr, ld_wr;
   logic [LANE_W-1:0] off_in, off_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [1:0] sz_q;
   logic we_q, uns_q, mis_q;
   logic [6:0] amt;
   logic [XLEN-1:0] lane, left, ext;
   logic signed [XLEN-1:0] sext;
   logic unused_opcode;
   assign unused_opcode = ^opcode_info_i;
   // state register; reset abandons any outstanding load so a later stray rvalid is ignored
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;
   // next state: flush in WAIT either discards a coincident response or drains the pending one
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = (accept & is_ld) ? WAIT : IDLE;
         WAIT:    state_n = mem_rvalid_i ? IDLE : (flush_i ? DRAIN : WAIT);
         default: state_n = mem_rvalid_i ? IDLE : DRAIN;
      endcase
   end
   // handshake, alignment check and write-strobe qualification
   always_comb begin
      ready_o = (state == IDLE);
      is_ld   = opcode_info_i[LOAD_BIT];
      accept  = valid_i & ready_o & ~flush_i;
      off_in  = alu_result_i[LANE_W-1:0];
      mis_in  = (ld_size_i == 2'd1) ? off_in[0] :
                (ld_size_i == 2'd2) ? |off_in[1:0] :
                (ld_size_i == 2'd3) ? ((XLEN != 64) | (|off_in)) : 1'b0;
      alu_wr  = accept & ~is_ld & rd_write_en_i & (rd_id_i != '0);
      ld_wr   = (state == WAIT) & mem_rvalid_i & ~flush_i & we_q & (rd_q != '0) & ~mis_q;
   end
   // lane extraction: shift the addressed lane to bit 0, left-justify it, then shift back to extend
   always_comb begin
      lane = mem_read_data_i >> {off_q, 3'b000};
      amt  = (sz_q == 2'd3) ? 7'd0 : 7'(XLEN - (8 << sz_q));
      left = lane << amt;
      sext = $signed(left) >>> amt;
      ext  = uns_q ? (left >> amt) : $unsigned(sext);
   end
   // capture load attributes at accept for use when the response arrives
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_q  <= '0;
         we_q  <= 1'b0;
         sz_q  <= 2'd0;
         uns_q <= 1'b0;
         off_q <= '0;
         mis_q <= 1'b0;
      end else if (accept & is_ld) begin
         rd_q  <= rd_id_i;
         we_q  <= rd_write_en_i;
         sz_q  <= ld_size_i;
         uns_q <= ld_unsigned_i;
         off_q <= off_in;
         mis_q <= mis_in;
      end
   // registered write-back outputs; id and data hold between writes
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wb_rd_write_en_o   <= 1'b0;
         wb_rd_id_o         <= '0;
         wb_rd_write_data_o <= '0;
         misalign_o         <= 1'b0;
      end else begin
         wb_rd_write_en_o <= alu_wr | ld_wr;
         misalign_o       <= accept & is_ld & mis_in;
         if (alu_wr) begin
            wb_rd_id_o         <= rd_id_i;
            wb_rd_write_data_o <= alu_result_i;
         end else if (ld_wr) begin
            wb_rd_id_o         <= rd_q;
            wb_rd_write_data_o <= ext;
         end
      end
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered write-back stage for the pipelined RV32/RV64 core.
- Accepts retiring instructions from MEM over a valid/ready handshake and selects the ALU result or load data.
- For loads, waits for a multi-cycle data-memory response, then extracts and sign/zero-extends the addressed byte, half, word or double lane.
- Drives a one-cycle register-file write pulse, supports pipeline flush of an outstanding load, and flags misaligned loads.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
REG_ADDR_W, 5, register index width
OPCODE_W, 10, width of one-hot opcode_info bus
LOAD_BIT, 4, bit of opcode_info_i that marks a load
LANE_W, $clog2(XLEN/8), width of the byte-offset field (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_i  in  1  MEM stage presents an instruction
ready_o  out  1  stage can accept an instruction this cycle
rd_write_en_i  in  1  instruction writes rd
rd_id_i  in  REG_ADDR_W  destination register
opcode_info_i  in  OPCODE_W  one-hot opcode class
alu_result_i  in  XLEN  ALU result / load address
ld_size_i  in  2  0 byte, 1 half, 2 word, 3 double (double legal only when XLEN=64)
ld_unsigned_i  in  1  zero-extend instead of sign-extend
flush_i  in  1  kill in-flight / presented instruction
mem_rvalid_i  in  1  load response valid
mem_read_data_i  in  XLEN  naturally aligned memory word (lane layout, not shifted)
wb_rd_write_en_o  out  1  register-file write strobe (one-cycle pulse)
wb_rd_id_o  out  REG_ADDR_W  write index
wb_rd_write_data_o  out  XLEN  write data
misalign_o  out  1  one-cycle pulse: misaligned load detected, write suppressed

Behaviour:
- Reset (async): state IDLE; all outputs 0 except ready_o, which is 1.
- States:
  - IDLE: ready_o=1.
  - WAIT: ready_o=0; a load is outstanding.
  - DRAIN: ready_o=0; a flushed load's response is still outstanding.
- Accept = valid_i & ready_o & ~flush_i. With flush_i=1 in IDLE, valid_i is ignored and nothing is written.
- Non-load accept (opcode_info_i[LOAD_BIT]=0):
  - Next edge: wb_rd_write_en_o = rd_write_en_i & (rd_id_i!=0); id and data = alu_result_i.
  - Latency 1 cycle; state stays IDLE, so back-to-back non-loads retire every cycle.
- Load accept:
  - Capture rd_id, rd_write_en, ld_size, ld_unsigned and offset = alu_result_i[LANE_W-1:0].
  - Misalignment check on the offset: half needs offset[0]=0; word needs offset[1:0]=0; double needs offset=0.
  - If misaligned: next edge pulse misalign_o=1, no write, go WAIT anyway (the response must still be consumed).
  - Otherwise go WAIT.
- mem_rvalid_i is only legal at least one cycle after load accept; it is ignored in IDLE.
- WAIT and mem_rvalid_i=1:
  - Extract lane data[8*offset +: size bits]; sign-extend from the lane MSB unless ld_unsigned.
  - Register to wb_rd_write_data_o; pulse write_en (suppressed if rd=0 or misaligned).
  - Go IDLE. Load-to-writeback latency = 1 cycle after rvalid.
- WAIT, flush_i=1, mem_rvalid_i=0: go DRAIN; no write.
- WAIT, flush_i=1 and mem_rvalid_i=1 same cycle: flush wins; response consumed and discarded; go IDLE.
- DRAIN: on mem_rvalid_i, discard and go IDLE; flush_i has no effect.
- Output pulses: wb_rd_write_en_o and misalign_o are high for exactly one cycle per event.
- Held values: wb_rd_id_o and wb_rd_write_data_o keep their last written values when write_en is 0.
- Reset mid-WAIT/DRAIN: immediate return to IDLE; any later stray rvalid is ignored.
- Widths: all extension to XLEN. Double-width loads at XLEN=32 are illegal and treated as misaligned.

Test Plan:
- ALU op: rd=5, alu_result=0x1234_5678, rd_write_en=1 -> next cycle write_en=1, id=5, data=0x12345678; back-to-back ALU ops to rd 5 and rd 6 retire on consecutive cycles.
- LB signed: addr low=2'b11, mem data=0x80AA_BBCC, rvalid 3 cycles after accept -> ready_o=0 for those cycles; cycle after rvalid data=0xFFFF_FF80.
- LHU: addr low=2'b10, mem data=0x80AA_BBCC -> data=0x0000_80AA.
- Misaligned LW at addr low=2'b01 -> misalign_o pulse the cycle after accept, no write; after rvalid, state returns to IDLE with ready_o=1.
- Flush in WAIT, rvalid 2 cycles later -> state DRAIN, no write, ready_o=1 only after rvalid.
- Flush coincident with rvalid -> no write, IDLE next cycle. rd=0 load -> write_en stays 0. Async rst asserted in WAIT -> all outputs 0, ready_o=1 immediately.
